// File: rtl/sdram_arbiter.sv
// Three-master round-robin front end for sdram_controller, with in-order read completion routing.
// Build option SDRAM_ARB_PRIORITY_EN: master 0 always wins; masters 1 and 2 round-robin.
`timescale 1ns/1ps
module sdram_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [25:0] m0_addr,
  input  logic        m0_write,
  input  logic        m0_burst,
  input  logic [3:0]  m0_byte_enable,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_rdvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_complete,
  input  logic        m1_req,
  input  logic [25:0] m1_addr,
  input  logic        m1_write,
  input  logic        m1_burst,
  input  logic [3:0]  m1_byte_enable,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_rdvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_complete,
  input  logic        m2_req,
  input  logic [25:0] m2_addr,
  input  logic        m2_write,
  input  logic        m2_burst,
  input  logic [3:0]  m2_byte_enable,
  input  logic [31:0] m2_wdata,
  output logic        m2_ack,
  output logic        m2_rdvalid,
  output logic [31:0] m2_rdata,
  output logic        m2_complete,
  output logic [2:0]  sdram_req,
  output logic [25:0] sdram_addr,
  output logic        sdram_write,
  output logic        sdram_burst,
  output logic [3:0]  sdram_byte_enable,
  output logic [31:0] sdram_wdata,
  input  logic        sdram_ack,
  input  logic [31:0] sdram_rdata,
  input  logic [2:0]  sdram_rdvalid,
  input  logic        sdram_complete
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_id, grant_id_d;
  logic [1:0]  rr_ptr, rr_ptr_d;
  logic [2:0]  pending, pending_d;
  logic        grant_valid;
  logic [2:0]  eligible;

  logic [1:0]  fifo_mem [3];
  logic [1:0]  fifo_rd, fifo_wr, fifo_cnt;
  logic [1:0]  fifo_rd_d, fifo_wr_d, fifo_cnt_d;
  logic [1:0]  fifo_head;
  logic        push, pop, ack_taken;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Winner search; caller guarantees at least one eligible master.
  function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
    logic [1:0] c0, c1, c2;
`ifdef SDRAM_ARB_PRIORITY_EN
    c0 = 2'd0;
    c1 = (ptr == 2'd2) ? 2'd2 : 2'd1;
    c2 = (ptr == 2'd2) ? 2'd1 : 2'd2;
`else
    c0 = (ptr >= 2'd3) ? 2'd0 : ptr;
    c1 = inc3(c0);
    c2 = inc3(c1);
`endif
    if (elig[c0])      return c0;
    else if (elig[c1]) return c1;
    else               return c2;
  endfunction

  assign grant_valid = (state_q == GRANTED);
  assign eligible    = {m2_req, m1_req, m0_req} & ~pending;
  assign ack_taken   = grant_valid & sdram_ack;
  assign fifo_head   = fifo_mem[fifo_rd];
  assign pop         = sdram_complete & (fifo_cnt != 2'd0);
  assign push        = ack_taken & ~sdram_write;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id;
    rr_ptr_d   = rr_ptr;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d    = GRANTED;
          grant_id_d = rr_pick(eligible, rr_ptr);
        end
      end
      GRANTED: begin
        if (sdram_ack) begin
          state_d = IDLE;
`ifdef SDRAM_ARB_PRIORITY_EN
          if (grant_id == 2'd1)      rr_ptr_d = 2'd2;
          else if (grant_id == 2'd2) rr_ptr_d = 2'd1;
`else
          rr_ptr_d = inc3(grant_id);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop the head before pushing so a same-cycle ack and complete stay ordered.
  always_comb begin
    pending_d  = pending;
    fifo_rd_d  = fifo_rd;
    fifo_wr_d  = fifo_wr;
    fifo_cnt_d = fifo_cnt;
    if (pop) begin
      pending_d[fifo_head] = 1'b0;
      fifo_rd_d            = inc3(fifo_rd);
    end
    if (push) begin
      pending_d[grant_id] = 1'b1;
      fifo_wr_d           = inc3(fifo_wr);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt - 2'd1;
      default: fifo_cnt_d = fifo_cnt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_id <= 2'd0;
      rr_ptr   <= 2'd0;
      pending  <= 3'b000;
      fifo_rd  <= 2'd0;
      fifo_wr  <= 2'd0;
      fifo_cnt <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_id_d;
      rr_ptr   <= rr_ptr_d;
      pending  <= pending_d;
      fifo_rd  <= fifo_rd_d;
      fifo_wr  <= fifo_wr_d;
      fifo_cnt <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[fifo_wr] <= grant_id;
  end

  always_comb begin
    sdram_req         = grant_valid ? (3'b001 << grant_id) : 3'b000;
    sdram_addr        = m0_addr;
    sdram_write       = m0_write;
    sdram_burst       = m0_burst;
    sdram_byte_enable = m0_byte_enable;
    sdram_wdata       = m0_wdata;
    case (grant_id)
      2'd1: begin
        sdram_addr        = m1_addr;
        sdram_write       = m1_write;
        sdram_burst       = m1_burst;
        sdram_byte_enable = m1_byte_enable;
        sdram_wdata       = m1_wdata;
      end
      2'd2: begin
        sdram_addr        = m2_addr;
        sdram_write       = m2_write;
        sdram_burst       = m2_burst;
        sdram_byte_enable = m2_byte_enable;
        sdram_wdata       = m2_wdata;
      end
      default: ;
    endcase
  end

  assign m0_ack      = ack_taken & (grant_id == 2'd0);
  assign m1_ack      = ack_taken & (grant_id == 2'd1);
  assign m2_ack      = ack_taken & (grant_id == 2'd2);
  assign m0_complete = pop & (fifo_head == 2'd0);
  assign m1_complete = pop & (fifo_head == 2'd1);
  assign m2_complete = pop & (fifo_head == 2'd2);
  assign m0_rdvalid  = sdram_rdvalid[0];
  assign m1_rdvalid  = sdram_rdvalid[1];
  assign m2_rdvalid  = sdram_rdvalid[2];
  assign m0_rdata    = sdram_rdata;
  assign m1_rdata    = sdram_rdata;
  assign m2_rdata    = sdram_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios then random traffic against a queue-based arbiter model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  logic        clock;
  logic        reset;
  logic [2:0]  mreq, mwrite, mburst, mack, mrdv, mcmp;
  logic [25:0] maddr [3];
  logic [3:0]  mbe [3];
  logic [31:0] mwdata [3];
  logic [31:0] rdata0, rdata1, rdata2;
  logic [2:0]  sdram_req;
  logic [25:0] sdram_addr;
  logic        sdram_write, sdram_burst;
  logic [3:0]  sdram_byte_enable;
  logic [31:0] sdram_wdata;
  logic        sdram_ack;
  logic [31:0] sdram_rdata;
  logic [2:0]  sdram_rdvalid;
  logic        sdram_complete;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state
  bit         m_granted;
  int         m_gid;
  int         m_rr;
  bit   [2:0] m_pend;
  int         m_fifo[$];
  logic [2:0] e_ack, e_cmp;

  sdram_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_write(mwrite[0]), .m0_burst(mburst[0]),
    .m0_byte_enable(mbe[0]), .m0_wdata(mwdata[0]), .m0_ack(mack[0]), .m0_rdvalid(mrdv[0]),
    .m0_rdata(rdata0), .m0_complete(mcmp[0]),
    .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_write(mwrite[1]), .m1_burst(mburst[1]),
    .m1_byte_enable(mbe[1]), .m1_wdata(mwdata[1]), .m1_ack(mack[1]), .m1_rdvalid(mrdv[1]),
    .m1_rdata(rdata1), .m1_complete(mcmp[1]),
    .m2_req(mreq[2]), .m2_addr(maddr[2]), .m2_write(mwrite[2]), .m2_burst(mburst[2]),
    .m2_byte_enable(mbe[2]), .m2_wdata(mwdata[2]), .m2_ack(mack[2]), .m2_rdvalid(mrdv[2]),
    .m2_rdata(rdata2), .m2_complete(mcmp[2]),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_write(sdram_write),
    .sdram_burst(sdram_burst), .sdram_byte_enable(sdram_byte_enable), .sdram_wdata(sdram_wdata),
    .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid),
    .sdram_complete(sdram_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      $error("comparison %s did not hold", tag);
    end
  endtask

  // Round-robin search among eligible masters starting at the pointer.
  function automatic int model_pick(input bit [2:0] elig);
`ifdef SDRAM_ARB_PRIORITY_EN
    int first;
    if (elig[0]) return 0;
    first = (m_rr == 2) ? 2 : 1;
    return elig[first] ? first : 3 - first;
`else
    for (int k = 0; k < 3; k++)
      if (elig[(m_rr + k) % 3]) return (m_rr + k) % 3;
    return 0;
`endif
  endfunction

  function automatic int model_next_rr(input int g);
`ifdef SDRAM_ARB_PRIORITY_EN
    if (g == 0) return m_rr;
    return (g == 1) ? 2 : 1;
`else
    return (g + 1) % 3;
`endif
  endfunction

  // Checks all outputs mid-cycle against the model, given the inputs driven at the falling edge.
  task automatic pre();
    logic [2:0] e_req;
    #1;
    e_req = m_granted ? 3'(3'b001 << m_gid) : 3'b000;
    e_ack = (m_granted && sdram_ack) ? e_req : 3'b000;
    e_cmp = (sdram_complete && m_fifo.size() > 0) ? 3'(3'b001 << m_fifo[0]) : 3'b000;
    check("sdram_req", 64'(sdram_req), 64'(e_req));
    check("ack", 64'(mack), 64'(e_ack));
    check("complete", 64'(mcmp), 64'(e_cmp));
    check("rdvalid", 64'(mrdv), 64'(sdram_rdvalid));
    check("rdata0", 64'(rdata0), 64'(sdram_rdata));
    check("rdata1", 64'(rdata1), 64'(sdram_rdata));
    check("rdata2", 64'(rdata2), 64'(sdram_rdata));
    if (m_granted) begin
      check("addr", 64'(sdram_addr), 64'(maddr[m_gid]));
      check("ctl", 64'({sdram_write, sdram_burst, sdram_byte_enable}),
            64'({mwrite[m_gid], mburst[m_gid], mbe[m_gid]}));
      check("wdata", 64'(sdram_wdata), 64'(mwdata[m_gid]));
    end
  endtask

  // Advances the model across the rising edge, then waits for the next falling edge.
  task automatic post();
    bit [2:0] elig;
    int h;
    elig = mreq & ~m_pend;
    if (reset) begin
      m_granted = 0;
      m_rr = 0;
      m_pend = 3'b000;
      m_fifo.delete();
    end else begin
      if (sdram_complete && m_fifo.size() > 0) begin
        h = m_fifo.pop_front();
        m_pend[h] = 1'b0;
      end
      if (m_granted) begin
        if (sdram_ack) begin
          if (!mwrite[m_gid]) begin
            m_pend[m_gid] = 1'b1;
            m_fifo.push_back(m_gid);
          end
          m_rr = model_next_rr(m_gid);
          m_granted = 0;
        end
      end else if (elig != 3'b000) begin
        m_gid = model_pick(elig);
        m_granted = 1;
      end
    end
    @(negedge clock);
  endtask

  task automatic grant_and_ack(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      sdram_ack = m_granted && (m_gid == n);
      pre();
      ok = mack[n];
      post();
    end
    sdram_ack = 1'b0;
  endtask

  initial begin
    logic       ok, bubble;
    int         age, n_acks;
    logic [2:0] order [4];
    logic [2:0] exp_order [4];
`ifdef SDRAM_ARB_PRIORITY_EN
    exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    order = '{3'b000, 3'b000, 3'b000, 3'b000};
    m_granted = 0; m_gid = 0; m_rr = 0; m_pend = 3'b000;
    e_ack = 3'b000; e_cmp = 3'b000;
    reset = 1'b1; sdram_ack = 1'b0; sdram_complete = 1'b0;
    sdram_rdvalid = 3'b000; sdram_rdata = 32'h0;
    mreq = 3'b111; mwrite = 3'b111; mburst = 3'b000;
    for (int n = 0; n < 3; n++) begin
      maddr[n] = 26'(32'h100 * (n + 1)); mbe[n] = 4'hF; mwdata[n] = 32'hA000_0000 + n;
    end
    @(posedge clock);
    @(negedge clock);

    // Reset held two cycles with every master requesting
    pre(); check("rst_idle_a", 64'(sdram_req), 64'(3'b000)); post();
    pre(); check("rst_idle_b", 64'(sdram_req), 64'(3'b000)); post();
    reset = 1'b0;
    pre(); post();
    pre(); check("rst_first_grant", 64'(sdram_req), 64'(3'b001)); post();

    // Round-robin writes, controller acks two cycles after each request appears
    age = 0; n_acks = 0; bubble = 1'b0;
    for (int i = 0; i < 30 && n_acks < 4; i++) begin
      age = m_granted ? age + 1 : -1;
      sdram_ack = m_granted && (age == 2);
      pre();
      if (bubble) check("rr_bubble", 64'(sdram_req), 64'(3'b000));
      bubble = (mack != 3'b000);
      if (mack != 3'b000) begin
        order[n_acks] = sdram_req;
        n_acks++;
      end
      post();
    end
    sdram_ack = 1'b0; mreq = 3'b000;
    check("rr_ack_count", 64'(n_acks), 64'(4));
    for (int k = 0; k < 4; k++) check("rr_order", 64'(order[k]), 64'(exp_order[k]));

    // Single read from master 1
    maddr[1] = 26'h0001000; mwrite[1] = 1'b0; mburst[1] = 1'b0; mreq = 3'b010;
    grant_and_ack(1, ok); check("rd1_ack", 64'(ok), 64'(1));
    mreq = 3'b000;
    sdram_rdvalid = 3'b010; sdram_rdata = 32'hDEADBEEF;
    pre();
    check("rd1_rdvalid", 64'(mrdv), 64'(3'b010));
    check("rd1_rdata", 64'(rdata1), 64'(32'hDEADBEEF));
    post();
    sdram_rdvalid = 3'b000; mreq = 3'b010; mwrite[1] = 1'b1; mwdata[1] = 32'h1234_5678;
    pre(); check("rd1_held_a", 64'(sdram_req), 64'(3'b000)); post();
    pre(); check("rd1_held_b", 64'(sdram_req), 64'(3'b000)); post();
    sdram_complete = 1'b1;
    pre(); check("rd1_complete", 64'(mcmp), 64'(3'b010)); post();
    sdram_complete = 1'b0;
    pre(); check("rd1_gap", 64'(sdram_req), 64'(3'b000)); post();
    grant_and_ack(1, ok); check("rd1_regrant", 64'(ok), 64'(1));
    mreq = 3'b000;

    // Completion ordering: master 2 burst then master 0 single
    maddr[2] = 26'h2000040; mwrite[2] = 1'b0; mburst[2] = 1'b1; mreq = 3'b100;
    grant_and_ack(2, ok); check("ord_m2_ack", 64'(ok), 64'(1));
    maddr[0] = 26'h0000800; mwrite[0] = 1'b0; mburst[0] = 1'b0; mreq = 3'b001;
    grant_and_ack(0, ok); check("ord_m0_ack", 64'(ok), 64'(1));
    mreq = 3'b000; sdram_complete = 1'b1;
    pre(); check("ord_first", 64'(mcmp), 64'(3'b100)); post();
    pre(); check("ord_second", 64'(mcmp), 64'(3'b001)); post();
    pre(); check("ord_stale", 64'(mcmp), 64'(3'b000)); post();
    sdram_complete = 1'b0;

    // Same-cycle push and pop
    mburst[2] = 1'b0; mreq = 3'b100;
    grant_and_ack(2, ok); check("pp_m2_ack", 64'(ok), 64'(1));
    mwrite[1] = 1'b0; mreq = 3'b010;
    pre(); post();
    sdram_ack = 1'b1; sdram_complete = 1'b1;
    pre();
    check("pp_m2_cmp", 64'(mcmp), 64'(3'b100));
    check("pp_m1_ack", 64'(mack), 64'(3'b010));
    post();
    sdram_ack = 1'b0; sdram_complete = 1'b0; mreq = 3'b000;
    pre(); check("pp_pending", 64'(dut.pending), 64'(3'b010)); post();
    sdram_complete = 1'b1;
    pre(); check("pp_m1_cmp", 64'(mcmp), 64'(3'b010)); post();
    sdram_complete = 1'b0;

    // Reset with a read outstanding, then a late complete
    mwrite[0] = 1'b0; mreq = 3'b001;
    grant_and_ack(0, ok); check("rst_rd_ack", 64'(ok), 64'(1));
    mreq = 3'b000; reset = 1'b1;
    pre(); post();
    reset = 1'b0; sdram_complete = 1'b1;
    pre(); check("rst_late_cmp", 64'(mcmp), 64'(3'b000)); post();
    sdram_complete = 1'b0;

`ifdef SDRAM_ARB_PRIORITY_EN
    // Master 0 wins whenever it requests
    mwrite = 3'b111; mreq = 3'b011;
    for (int i = 0; i < 12; i++) begin
      sdram_ack = m_granted;
      pre();
      if (mack != 3'b000) check("prio_m0_wins", 64'(mack), 64'(3'b001));
      post();
    end
    mreq = 3'b010;
    grant_and_ack(1, ok); check("prio_m1_alone", 64'(ok), 64'(1));
    mreq = 3'b000;
`endif

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 3; n++) begin
        if (mreq[n] && e_ack[n]) mreq[n] = 1'b0;
        else if (!mreq[n] && $urandom_range(0, 3) == 0) begin
          mreq[n]   = 1'b1;
          maddr[n]  = 26'($urandom);
          mwrite[n] = 1'($urandom_range(0, 1));
          mburst[n] = mwrite[n] ? 1'b0 : 1'($urandom_range(0, 1));
          mbe[n]    = 4'($urandom);
          mwdata[n] = $urandom;
        end
      end
      sdram_ack      = m_granted && ($urandom_range(0, 2) == 0);
      sdram_complete = ($urandom_range(0, 4) == 0);
      sdram_rdvalid  = 3'(3'b001 << $urandom_range(0, 3));
      sdram_rdata    = $urandom;
      reset          = ($urandom_range(0, 199) == 0);
      pre();
      post();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
